// File: rtl/uart_pkg.sv
// Shared constants and elaboration-time helpers for the UART baud generator.
package uart_pkg;

  // Smallest integer divisor the generator will run with.
  localparam int unsigned DIV_MIN = 2;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int unsigned clog2(input longint unsigned v);
    longint unsigned x;
    int unsigned     r;
    r = 0;
    if (v > 1) begin
      x = v - 1;
      while (x > 0) begin
        x = x >> 1;
        r++;
      end
    end
    return r;
  endfunction

  // Width of the oversample phase counter, never below one bit.
  function automatic int unsigned os_width(input int unsigned oversample);
    return (clog2(oversample) < 1) ? 1 : clog2(oversample);
  endfunction

  // Rounded fixed-point divisor: clock*2^frac_w / (baud*oversample).
  function automatic longint unsigned def_div(input longint unsigned clock_rate,
                                              input longint unsigned baud_rate,
                                              input longint unsigned oversample,
                                              input int unsigned     frac_w);
    longint unsigned den;
    den = baud_rate * oversample;
    return ((clock_rate << frac_w) + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_gen_frac_if.sv
// Control and timing-output bundle of the fractional baud generator.
interface uart_baud_gen_frac_if import uart_pkg::*; #(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 8,
  parameter int unsigned OVERSAMPLE = 16
);
  localparam int unsigned OS_W = os_width(OVERSAMPLE);

  logic              enable;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              sync_clr;
  logic              os_en;
  logic              bit_en;
  logic [OS_W-1:0]   os_phase;
  logic              cfg_pending;

  modport master (
    output enable, div_int, div_frac, div_load, sync_clr,
    input  os_en, bit_en, os_phase, cfg_pending
  );

  modport slave (
    input  enable, div_int, div_frac, div_load, sync_clr,
    output os_en, bit_en, os_phase, cfg_pending
  );
endinterface

// File: rtl/uart_frac_accum.sv
// Fractional accumulator: adds the fraction on each period reload and
// reports the carry that stretches that period by one clock.
module uart_frac_accum #(
  parameter int unsigned FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              reload,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  // One-bit-wider sum so the carry is the top bit.
  always_comb sum = {1'b0, acc} + {1'b0, frac};

  assign carry = sum[FRAC_W];

  // Clear wins over reload so a phase resync always starts from zero residue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         acc <= '0;
    else if (clr)    acc <= '0;
    else if (reload) acc <= sum[FRAC_W-1:0];
  end
endmodule

// File: rtl/uart_baud_gen_frac.sv
// Runtime-programmable fractional baud generator: oversample enable,
// bit enable and oversample phase from a fixed-point divisor.
module uart_baud_gen_frac import uart_pkg::*; #(
  parameter int unsigned CLOCK_RATE = 40_000_000,
  parameter int unsigned BAUD_RATE  = 9_600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_baud_gen_frac_if.slave  bus
);
  localparam int unsigned       OS_W     = os_width(OVERSAMPLE);
  localparam longint unsigned   DEF_DIV  = def_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE, FRAC_W);
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_DIV >> FRAC_W);
  localparam logic [DIV_W-1:0]  DEF_CNT  = DIV_W'((DEF_DIV >> FRAC_W) - 1);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_DIV);
  localparam logic [OS_W-1:0]   PH_LAST  = OS_W'(OVERSAMPLE - 1);

  logic [DIV_W-1:0]  cnt, int_act, int_sh, load_int, nxt_int;
  logic [FRAC_W-1:0] frac_act, frac_sh, nxt_frac;
  logic [DIV_W:0]    period;
  logic [OS_W-1:0]   phase;
  logic              pending, upd, wrap, reload, apply, carry;
  logic              os_en_q, bit_en_q;

  // Divisor selection: a same-cycle load beats the shadow, which beats the
  // active value, so whichever divisor is applied is always the latest one.
  always_comb begin
    load_int = (bus.div_int < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : bus.div_int;
    upd      = pending | bus.div_load;
    nxt_int  = int_act;
    nxt_frac = frac_act;
    if (bus.div_load) begin
      nxt_int  = load_int;
      nxt_frac = bus.div_frac;
    end else if (pending) begin
      nxt_int  = int_sh;
      nxt_frac = frac_sh;
    end
    wrap   = bus.enable && (cnt == '0);
    reload = wrap && !bus.sync_clr;
    apply  = upd && (bus.sync_clr || !bus.enable || wrap);
    period = {1'b0, nxt_int} + {{DIV_W{1'b0}}, carry};
  end

  uart_frac_accum #(.FRAC_W(FRAC_W)) u_accum (
    .clk    (clk),
    .rst    (rst),
    .clr    (bus.sync_clr),
    .reload (reload),
    .frac   (nxt_frac),
    .carry  (carry)
  );

  // Shadow divisor capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_sh  <= DEF_INT;
      frac_sh <= DEF_FRAC;
    end else if (bus.div_load) begin
      int_sh  <= load_int;
      frac_sh <= bus.div_frac;
    end
  end

  // Active divisor and pending flag; applied on reload, resync or while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_act  <= DEF_INT;
      frac_act <= DEF_FRAC;
      pending  <= 1'b0;
    end else begin
      if (apply) begin
        int_act  <= nxt_int;
        frac_act <= nxt_frac;
      end
      pending <= upd && !apply;
    end
  end

  // Period down-counter; resync outranks the terminal-count reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= DEF_CNT;
    else if (bus.sync_clr)  cnt <= nxt_int - DIV_W'(1);
    else if (reload)        cnt <= DIV_W'(period - (DIV_W + 1)'(1));
    else if (bus.enable)    cnt <= cnt - DIV_W'(1);
  end

  // Registered tick, bit enable and oversample phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_en_q  <= 1'b0;
      bit_en_q <= 1'b0;
      phase    <= '0;
    end else if (bus.sync_clr) begin
      os_en_q  <= 1'b0;
      bit_en_q <= 1'b0;
      phase    <= '0;
    end else begin
      os_en_q  <= reload;
      bit_en_q <= reload && (phase == PH_LAST);
      if (reload) phase <= (phase == PH_LAST) ? '0 : phase + OS_W'(1);
    end
  end

  assign bus.os_en       = os_en_q;
  assign bus.bit_en      = bit_en_q;
  assign bus.os_phase    = phase;
  assign bus.cfg_pending = pending;
endmodule

// File: doc/uart_baud_gen_frac.md
Name: uart_baud_gen_frac

Overview:
- Runtime-programmable fractional baud generator for the UART TX/RX datapaths.
- Produces a one-clock oversample enable, a per-bit enable and the oversample phase count.
- The divisor is fixed-point (integer plus fraction). The fractional part is spread as a long-run average, so high baud rates stay accurate on odd clocks.
- The divisor can be changed live without glitches. The phase can be re-aligned, for example on an RX start-bit edge.

Parameters:
- CLOCK_RATE, 40_000_000: system clock frequency in Hz; used only for the reset divisor.
- BAUD_RATE, 9_600: reset baud rate in bps.
- OVERSAMPLE, 16: oversample enables per bit; must be at least 2.
- DIV_W, 16: width of the integer divisor.
- FRAC_W, 8: width of the fractional divisor.
- Derived OS_W = clog2(OVERSAMPLE), minimum 1.
- Derived DEF_DIV = round(CLOCK_RATE*2^FRAC_W / (BAUD_RATE*OVERSAMPLE)), computed in 64-bit. For the defaults this gives 66667, i.e. integer 260, fraction 0x6B.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset; asynchronous, active-high.
- enable, in, 1: run the generator; when low, counters hold.
- div_int, in, DIV_W: new integer divisor (clocks per oversample tick).
- div_frac, in, FRAC_W: new fractional divisor, in units of 1/2^FRAC_W.
- div_load, in, 1: one-cycle strobe that captures div_int and div_frac.
- sync_clr, in, 1: one-cycle strobe that restarts the period and the phase.
- os_en, out, 1: oversample enable, one-clock pulse.
- bit_en, out, 1: bit enable; asserted with the os_en that wraps os_phase.
- os_phase, out, OS_W: count of os_en pulses modulo OVERSAMPLE.
- cfg_pending, out, 1: a loaded divisor is waiting to be applied.

Behaviour:
- Reset values:
  - All outputs 0.
  - Active divisor = DEF_DIV.
  - Fraction accumulator acc = 0.
  - Down-counter cnt = DEF_DIV integer part - 1.
  - Shadow divisor = DEF_DIV.
- Effective integer divisor is max(div_int, 2); values 0 and 1 are clamped to 2 at capture time.
- Period P:
  - At each period reload: acc_next = acc + frac_active, computed FRAC_W+1 wide.
  - carry = bit FRAC_W of that sum; acc takes the low FRAC_W bits.
  - P = int_active + carry.
- Counting:
  - While enable=1, cnt decrements every clock.
  - When cnt==0, cnt reloads with P-1 for the next period.
- os_en is a flop output:
  - Set in the cycle in which cnt==0, so there is exactly one pulse every P clocks.
  - The first pulse comes P clocks after the first enabled edge.
- os_phase:
  - Increments on every os_en, wrapping OVERSAMPLE-1 -> 0.
  - bit_en is high in the same cycle as the os_en where os_phase transitions OVERSAMPLE-1 -> 0.
- os_en, bit_en and os_phase update together as registered outputs, with no combinational path from inputs.
- div_load:
  - Captures the clamped div_int and div_frac into the shadow registers and sets cfg_pending.
  - When enable=1, the shadow is copied to the active divisor at the next period reload (cnt==0); cfg_pending clears at that point.
  - When enable=0, the shadow is applied on the next clock.
  - A second div_load while pending overwrites the shadow; only the latest value is applied.
- sync_clr:
  - Next cycle: cnt = int_active - 1, acc = 0, os_phase = 0.
  - os_en and bit_en are forced 0 in the cycle after the strobe.
  - Any pending shadow is applied at once.
  - If div_load and sync_clr occur in the same cycle, the new divisor is applied immediately.
- enable=0:
  - cnt, acc and os_phase hold; os_en and bit_en are 0.
  - Re-enabling resumes the interrupted period; there is no restart.
- sync_clr takes priority over a cnt==0 reload in the same cycle.
- rst mid-period: all state returns to reset values asynchronously, including the shadow divisor and cfg_pending.
- Long-run average period = (int + frac/2^FRAC_W) clocks, with jitter of at most 1 clock per tick.

Decomposition:
- Shared package uart_pkg holds:
  - the clog2 function;
  - the default-divisor calculation;
  - the DIV_MIN = 2 constant;
  - OVERSAMPLE-related widths.
- One natural sub-module, uart_frac_accum: the fraction accumulator with carry-out and a reload strobe input.
- The top module keeps the down-counter, the shadow/apply logic and the phase counter.

Test Plan:
- Reset release, enable=1, defaults:
  - periods are 260 or 261 clocks;
  - over 256 ticks the sum is 66667 +/- 1 clocks;
  - bit_en occurs every 16th os_en.
- div_load with int=4, frac=0x80, enable=0, then enable=1:
  - periods 4,5,4,5 (first carry on the 2nd tick);
  - os_en spacing matches exactly.
- Load int=8, frac=0 mid-period while running at int=4:
  - cfg_pending stays high until the current period ends;
  - the next period is 8 clocks, with no short or merged pulse.
- Load int=1:
  - period clamps to 2 clocks (os_en every other clock);
  - bit_en every 32 clocks with OVERSAMPLE=16.
- sync_clr pulse at os_phase=7, mid-period:
  - os_phase becomes 0 and no os_en appears the next cycle;
  - the next os_en arrives int_active clocks after the strobe;
  - bit_en occurs 16 ticks later.
- enable dropped for 10 clocks mid-period, then restored:
  - no os_en while low;
  - the remaining period count is preserved.
- rst asserted asynchronously mid-period:
  - outputs drop to 0 without waiting for a clock edge;
  - the divisor returns to 260/0x6B.
